// File: rtl/serial_alu_ctrl_pkg.sv
// Shared opcodes and controller state encoding for the bit-serial ALU.
package serial_alu_ctrl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_alu_ctrl_alu_bit_slice.sv
// Combinational 1-bit ALU slice: logic ops ignore the carry, ADD/SUB use a full adder.
module alu_bit_slice
  import serial_alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout
);

  // SUB arrives here as ADD with b already inverted and cin preset to 1.
  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer, LSB first, start/busy/done handshake.
// Optional zero/ovf flag outputs are enabled by defining SERIAL_ALU_FLAGS_EN.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-2:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             slice_r, slice_cout;
  logic             accept, last_bit;

  alu_bit_slice u_slice (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry),
    .op   (op_reg),
    .r    (slice_r),
    .cout (slice_cout)
  );

  assign accept     = start && (state == ST_IDLE || state == ST_DONE);
  assign last_bit   = (state == ST_RUN) && (cnt == LAST);
  // Only WIDTH-1 bits are stored; the final slice bit completes the word on entry to DONE.
  assign shift_next = {slice_r, shift_reg};
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_AND;
      cnt       <= '0;
      carry     <= 1'b0;
      shift_reg <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      a_reg  <= a;
      b_reg  <= (op == OP_SUB) ? ~b : b;
      op_reg <= op;
      cnt    <= '0;
      carry  <= (op == OP_SUB);
    end else if (state == ST_RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      carry     <= slice_cout;
      cnt       <= cnt + CNT_W'(1);
      shift_reg <= shift_next[WIDTH-1:1];
      if (last_bit) begin
        result    <= shift_next;
        carry_out <= op_reg[1] & slice_cout;
`ifdef SERIAL_ALU_FLAGS_EN
        zero      <= (shift_next == '0);
        ovf       <= op_reg[1] & (carry ^ slice_cout);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Randomized self-checking bench for serial_alu_ctrl against an arithmetic reference model.
module tb_serial_alu_ctrl;

  localparam int W = 8;
  localparam logic [1:0] T_AND = 2'b00, T_OR = 2'b01, T_ADD = 2'b10, T_SUB = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy, done, carry_out;
  logic [W-1:0] result;
`ifdef SERIAL_ALU_FLAGS_EN
  logic         zero, ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_result, held_result;
  logic         exp_carry, exp_ovf;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the whole word.
  task automatic modelAlu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ua, ub, sum;
    int sa, sb, s;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    exp_carry = 1'b0;
    exp_ovf   = 1'b0;
    case (op)
      T_AND: exp_result = a & b;
      T_OR:  exp_result = a | b;
      T_ADD: begin
        sum = ua + ub;
        exp_result = W'(sum);
        exp_carry  = (sum >= (1 << W));
        s = sa + sb;
        exp_ovf = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
      end
      default: begin
        exp_result = W'(ua - ub);
        exp_carry  = (ua >= ub);
        s = sa - sb;
        exp_ovf = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
      end
    endcase
  endtask

  // back=1 drives start during the current DONE cycle instead of waiting a negedge.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit back);
    if (!back) @(negedge clk);
    op_i  = op;
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    modelAlu(op, a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i  = 2'($urandom_range(0, 3));
    a_i   = W'($urandom);
    b_i   = W'($urandom);
  endtask

  task automatic checkResult(input int poke);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      checkOutput("busy_run", busy, 1);
      checkOutput("done_in_run", done, 0);
      checkOutput("result_held", result, held_result);
      if (k == poke) begin
        start = 1'b1;
        op_i  = 2'($urandom_range(0, 3));
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("result", result, exp_result);
    checkOutput("carry_out", carry_out, exp_carry);
`ifdef SERIAL_ALU_FLAGS_EN
    checkOutput("zero", zero, (exp_result == '0));
    checkOutput("ovf", ovf, exp_ovf);
`endif
    held_result = exp_result;
  endtask

  task automatic doOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit back, input int poke);
    applyStimulus(op, a, b, back);
    checkResult(poke);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    held_result = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_carry", carry_out, 0);
    rst = 1'b0;

    doOp(T_ADD, 8'h3C, 8'h0F, 0, 0);
    doOp(T_ADD, 8'hFF, 8'h01, 0, 4);
    doOp(T_SUB, 8'h05, 8'h07, 1, 0);
    doOp(T_SUB, 8'h80, 8'h01, 1, W);
    doOp(T_AND, 8'hA5, 8'h0F, 0, 0);
    doOp(T_OR,  8'hA5, 8'h0F, 0, 1);

    // Reset in the middle of a run discards the partial operation.
    applyStimulus(T_ADD, 8'h55, 8'h66, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_carry", carry_out, 0);
    held_result = '0;
    doOp(T_ADD, 8'h01, 8'h01, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 7 == 3) ra = '1;
      if (i % 5 == 2) rb = '0;
      doOp(2'($urandom_range(0, 3)), ra, rb, bit'($urandom_range(0, 1)), $urandom_range(0, W));
    end

    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_result", result, held_result);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
